// File: rtl/l2_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : l2_request_arbiter
//  Purpose  : Queues eviction writes and line-fill reads from two L1 snooper
//             ports and serialises them round-robin onto one L2/memory port.
//             Routes each fill back to the L1 that requested it.
//  Revision : 1.0  initial release
// ============================================================================
module l2_request_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] l1a_addr,
  input  logic [LINE_W-1:0] l1a_evict_line,
  input  logic              l1a_evict_wren,
  input  logic              l1a_read_req,
  output logic [LINE_W-1:0] l1a_fill_line,
  output logic              l1a_fill_valid,

  input  logic [ADDR_W-1:0] l1b_addr,
  input  logic [LINE_W-1:0] l1b_evict_line,
  input  logic              l1b_evict_wren,
  input  logic              l1b_read_req,
  output logic [LINE_W-1:0] l1b_fill_line,
  output logic              l1b_fill_valid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,

  output logic              overflow_a,
  output logic              overflow_b
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + ADDR_W + LINE_W;   // {is_write, addr, line}

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2
  } state_t;

  // Per-port request views, index 0 = L1a, index 1 = L1b
  logic [1:0]        req_wr;
  logic [1:0]        req_rd;
  logic [ADDR_W-1:0] req_addr [2];
  logic [LINE_W-1:0] req_line [2];

  assign req_wr      = {l1b_evict_wren, l1a_evict_wren};
  assign req_rd      = {l1b_read_req,   l1a_read_req};
  assign req_addr[0] = l1a_addr;
  assign req_addr[1] = l1b_addr;
  assign req_line[0] = l1a_evict_line;
  assign req_line[1] = l1b_evict_line;

  logic [1:0]       fifo_empty;
  logic [1:0]       pop;
  logic [1:0]       ovf;
  logic [ENT_W-1:0] head [2];

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ENT_W-1:0] store_q [FIFO_DEPTH];
    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic [PTR_W:0]   wptr_p1;
    logic [PTR_W:0]   used;
    logic [PTR_W:0]   slots_free;
    logic             acc_w;
    logic             acc_r;
    logic             drop;
    logic             ovf_q;

    // A slot being popped this cycle is usable by an enqueue in the same cycle
    assign used       = wptr_q - rptr_q;
    assign slots_free = (PTR_W+1)'(FIFO_DEPTH) - used + {{PTR_W{1'b0}}, pop[p]};
    assign wptr_p1    = wptr_q + {{PTR_W{1'b0}}, 1'b1};

    // Write goes in first; the read only gets a slot if one is left after it
    assign acc_w = req_wr[p] & (slots_free != '0);
    assign acc_r = req_rd[p] & (acc_w ? (slots_free >= (PTR_W+1)'(2))
                                      : (slots_free != '0));
    assign drop  = (req_wr[p] & ~acc_w) | (req_rd[p] & ~acc_r);

    assign fifo_empty[p] = (wptr_q == rptr_q);
    assign head[p]       = store_q[rptr_q[PTR_W-1:0]];
    assign ovf[p]        = ovf_q;

    // Next pointer values from accepted enqueues and the arbiter's pop
    always_comb begin
      wptr_d = wptr_q + {{PTR_W{1'b0}}, acc_w} + {{PTR_W{1'b0}}, acc_r};
      rptr_d = rptr_q + {{PTR_W{1'b0}}, pop[p]};
    end

    // Entry storage; a combined request writes two consecutive slots
    always_ff @(posedge clk) begin
      if (acc_w) begin
        store_q[wptr_q[PTR_W-1:0]] <= {1'b1, req_addr[p], req_line[p]};
      end
      if (acc_r) begin
        store_q[acc_w ? wptr_p1[PTR_W-1:0] : wptr_q[PTR_W-1:0]] <=
          {1'b0, req_addr[p], {LINE_W{1'b0}}};
      end
    end

    // Pointer registers and the sticky drop flag
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wptr_q <= '0;
        rptr_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
        if (drop) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------------
  // Arbiter / issue FSM
  // ------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;   // 0 = A, 1 = B
  logic              iss_write_q, iss_write_d;
  logic              iss_owner_q, iss_owner_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic [LINE_W-1:0] iss_line_q, iss_line_d;
  logic              grant_b;
  logic [ENT_W-1:0]  head_sel;

  // Next-state, round-robin grant and head pop
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    iss_write_d  = iss_write_q;
    iss_owner_d  = iss_owner_q;
    iss_addr_d   = iss_addr_q;
    iss_line_d   = iss_line_q;
    pop          = 2'b00;
    grant_b      = 1'b0;
    head_sel     = head[0];

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty[0] || !fifo_empty[1]) begin
          // B wins if A is empty, or both are waiting and A went last
          grant_b      = fifo_empty[0] | (~fifo_empty[1] & ~last_grant_q);
          head_sel     = grant_b ? head[1] : head[0];
          pop          = grant_b ? 2'b10 : 2'b01;
          iss_write_d  = head_sel[ENT_W-1];
          iss_addr_d   = head_sel[ENT_W-2 -: ADDR_W];
          // Write data register only moves on writes so mem_wdata holds
          if (head_sel[ENT_W-1]) begin
            iss_line_d = head_sel[LINE_W-1:0];
          end
          iss_owner_d  = grant_b;
          last_grant_d = grant_b;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = iss_write_q ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (mem_rdata_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and issue registers; last_grant starts at B so A wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      iss_write_q  <= 1'b0;
      iss_owner_q  <= 1'b0;
      iss_addr_q   <= '0;
      iss_line_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      iss_write_q  <= iss_write_d;
      iss_owner_q  <= iss_owner_d;
      iss_addr_q   <= iss_addr_d;
      iss_line_q   <= iss_line_d;
    end
  end

  assign mem_addr  = iss_addr_q;
  assign mem_wdata = iss_line_q;
  assign mem_wren  = (state_q == ST_ISSUE) &  iss_write_q;
  assign mem_rden  = (state_q == ST_ISSUE) & ~iss_write_q;

  // ------------------------------------------------------------------------
  // Fill return path
  // ------------------------------------------------------------------------
  logic              fill_hit;
  logic [LINE_W-1:0] fill_a_q, fill_b_q;
  logic              fvalid_a_q, fvalid_b_q;

  // Read data only counts while a read is outstanding
  assign fill_hit = (state_q == ST_WAIT_RD) & mem_rdata_valid;

  // Capture read data into the owner's fill register and pulse its valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_a_q   <= '0;
      fill_b_q   <= '0;
      fvalid_a_q <= 1'b0;
      fvalid_b_q <= 1'b0;
    end else begin
      fvalid_a_q <= fill_hit & ~iss_owner_q;
      fvalid_b_q <= fill_hit &  iss_owner_q;
      if (fill_hit && !iss_owner_q) begin
        fill_a_q <= mem_rdata;
      end
      if (fill_hit && iss_owner_q) begin
        fill_b_q <= mem_rdata;
      end
    end
  end

  assign l1a_fill_line  = fill_a_q;
  assign l1b_fill_line  = fill_b_q;
  assign l1a_fill_valid = fvalid_a_q;
  assign l1b_fill_valid = fvalid_b_q;
  assign overflow_a     = ovf[0];
  assign overflow_b     = ovf[1];

endmodule
`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_l2_request_arbiter
//  Purpose  : Directed self-checking bench for l2_request_arbiter with a
//             fixed-latency (5 cycle) memory model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_l2_request_arbiter;

  logic          clk;
  logic          reset;
  logic [31:0]   l1a_addr, l1b_addr;
  logic [127:0]  l1a_evict_line, l1b_evict_line;
  logic          l1a_evict_wren, l1b_evict_wren;
  logic          l1a_read_req, l1b_read_req;
  logic [127:0]  l1a_fill_line, l1b_fill_line;
  logic          l1a_fill_valid, l1b_fill_valid;
  logic [31:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic          mem_wren, mem_rden;
  logic [127:0]  mem_rdata;
  logic          mem_rdata_valid;
  logic          overflow_a, overflow_b;

  l2_request_arbiter #(.ADDR_W(32), .LINE_W(128), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .l1a_addr       (l1a_addr),
    .l1a_evict_line (l1a_evict_line),
    .l1a_evict_wren (l1a_evict_wren),
    .l1a_read_req   (l1a_read_req),
    .l1a_fill_line  (l1a_fill_line),
    .l1a_fill_valid (l1a_fill_valid),
    .l1b_addr       (l1b_addr),
    .l1b_evict_line (l1b_evict_line),
    .l1b_evict_wren (l1b_evict_wren),
    .l1b_read_req   (l1b_read_req),
    .l1b_fill_line  (l1b_fill_line),
    .l1b_fill_valid (l1b_fill_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wren       (mem_wren),
    .mem_rden       (mem_rden),
    .mem_rdata      (mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .overflow_a     (overflow_a),
    .overflow_b     (overflow_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_line(input logic [31:0] a);
    return {a, ~a, a + 32'h1111_1111, 32'hFEED_0000};
  endfunction

  // Memory model: read data returned 5 cycles after mem_rden
  int          mdl_cnt = 0;
  logic [31:0] mdl_addr = '0;
  initial begin
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
  end
  always @(negedge clk) begin
    mem_rdata_valid = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = model_line(mdl_addr);
      end
    end
    if (mem_rden === 1'b1) begin
      mdl_cnt  = 5;
      mdl_addr = mem_addr;
    end
  end

  // Event logs with the cycle each event was seen in
  typedef struct {
    int           cyc;
    logic [31:0]  addr;
    logic [127:0] data;
  } ev_t;
  ev_t rd_log[$], wr_log[$], fa_log[$], fb_log[$];

  always @(negedge clk) begin
    if (mem_rden === 1'b1)       rd_log.push_back('{cyc, mem_addr, '0});
    if (mem_wren === 1'b1)       wr_log.push_back('{cyc, mem_addr, mem_wdata});
    if (l1a_fill_valid === 1'b1) fa_log.push_back('{cyc, 32'h0, l1a_fill_line});
    if (l1b_fill_valid === 1'b1) fb_log.push_back('{cyc, 32'h0, l1b_fill_line});
  end

  task automatic clear_inputs();
    l1a_evict_wren = 1'b0; l1a_read_req = 1'b0;
    l1b_evict_wren = 1'b0; l1b_read_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd_log.delete(); wr_log.delete(); fa_log.delete(); fb_log.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " mem_addr"},  mem_addr,  '0);
    check_eq({tag, " mem_wdata"}, mem_wdata, '0);
    check_eq({tag, " wren"},      mem_wren,  '0);
    check_eq({tag, " rden"},      mem_rden,  '0);
    check_eq({tag, " fva"},       l1a_fill_valid, '0);
    check_eq({tag, " fvb"},       l1b_fill_valid, '0);
    check_eq({tag, " fla"},       l1a_fill_line,  '0);
    check_eq({tag, " flb"},       l1b_fill_line,  '0);
    check_eq({tag, " ovfa"},      overflow_a, '0);
    check_eq({tag, " ovfb"},      overflow_b, '0);
  endtask

  function automatic logic [31:0] log_addr(input ev_t q[$], input int i);
    return (i < q.size()) ? q[i].addr : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [127:0] log_data(input ev_t q[$], input int i);
    return (i < q.size()) ? q[i].data : '1;
  endfunction
  function automatic int log_cyc(input ev_t q[$], input int i);
    return (i < q.size()) ? q[i].cyc : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    logic [31:0] t3_exp [5];
    t3_exp[0] = 32'h10; t3_exp[1] = 32'h50; t3_exp[2] = 32'h20;
    t3_exp[3] = 32'h60; t3_exp[4] = 32'h30;

    reset = 1'b0;
    l1a_addr = '0; l1b_addr = '0; l1a_evict_line = '0; l1b_evict_line = '0;
    clear_inputs();

    // Reset state
    do_reset();
    check_all_zero("rst");

    // Test 1: single A read
    l1a_addr = 32'h40; l1a_read_req = 1'b1; t0 = cyc;
    @(negedge clk); clear_inputs();
    repeat (14) @(negedge clk);
    check_eq("t1 rd cnt",   rd_log.size(), 1);
    check_eq("t1 rd addr",  log_addr(rd_log, 0), 32'h40);
    check_eq("t1 rd lat",   log_cyc(rd_log, 0) - t0, 2);
    check_eq("t1 fa cnt",   fa_log.size(), 1);
    check_eq("t1 fa lat",   log_cyc(fa_log, 0) - t0, 8);
    check_eq("t1 fa data",  log_data(fa_log, 0), model_line(32'h40));
    check_eq("t1 fb cnt",   fb_log.size(), 0);
    check_eq("t1 addr hold", mem_addr, 32'h40);
    check_eq("t1 fla hold", l1a_fill_line, model_line(32'h40));

    // Test 2: A write and B read in the same cycle
    do_reset();
    l1a_addr = 32'h100; l1a_evict_line = 128'hDEAD_BEEF; l1a_evict_wren = 1'b1;
    l1b_addr = 32'h200; l1b_read_req = 1'b1; t0 = cyc;
    @(negedge clk); clear_inputs();
    repeat (16) @(negedge clk);
    check_eq("t2 wr cnt",   wr_log.size(), 1);
    check_eq("t2 wr addr",  log_addr(wr_log, 0), 32'h100);
    check_eq("t2 wr data",  log_data(wr_log, 0), 128'hDEAD_BEEF);
    check_eq("t2 wr lat",   log_cyc(wr_log, 0) - t0, 2);
    check_eq("t2 rd addr",  log_addr(rd_log, 0), 32'h200);
    check_eq("t2 rd lat",   log_cyc(rd_log, 0) - t0, 4);
    check_eq("t2 fb cnt",   fb_log.size(), 1);
    check_eq("t2 fb data",  log_data(fb_log, 0), model_line(32'h200));
    check_eq("t2 fb lat",   log_cyc(fb_log, 0) - t0, 10);
    check_eq("t2 fa cnt",   fa_log.size(), 0);
    check_eq("t2 fla hold", l1a_fill_line, '0);

    // Test 3: round-robin between queued reads
    do_reset();
    l1a_addr = 32'h10; l1a_read_req = 1'b1; l1b_addr = 32'h50; l1b_read_req = 1'b1;
    @(negedge clk);
    l1a_addr = 32'h20; l1b_addr = 32'h60;
    @(negedge clk);
    l1a_addr = 32'h30; l1b_read_req = 1'b0;
    @(negedge clk); clear_inputs();
    repeat (60) @(negedge clk);
    check_eq("t3 rd cnt", rd_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("t3 rd%0d addr", i), log_addr(rd_log, i), t3_exp[i]);
    end
    check_eq("t3 fa cnt", fa_log.size(), 3);
    check_eq("t3 fb cnt", fb_log.size(), 2);
    check_eq("t3 fb1 data", log_data(fb_log, 1), model_line(32'h60));

    // Test 4: write and read on the same address in one cycle
    do_reset();
    l1a_addr = 32'h80; l1a_evict_line = 128'h1234; l1a_evict_wren = 1'b1;
    l1a_read_req = 1'b1; t0 = cyc;
    @(negedge clk); clear_inputs();
    repeat (14) @(negedge clk);
    check_eq("t4 wr addr", log_addr(wr_log, 0), 32'h80);
    check_eq("t4 wr lat",  log_cyc(wr_log, 0) - t0, 2);
    check_eq("t4 rd addr", log_addr(rd_log, 0), 32'h80);
    check_eq("t4 rd lat",  log_cyc(rd_log, 0) - t0, 4);
    check_eq("t4 fa data", log_data(fa_log, 0), model_line(32'h80));

    // Test 5: A write burst overflows while a B read is outstanding
    do_reset();
    l1b_addr = 32'h300; l1b_read_req = 1'b1;
    @(negedge clk); clear_inputs();
    check_eq("t5 ovfa pre", overflow_a, 1'b0);
    for (int i = 0; i < 6; i++) begin
      l1a_addr = 32'h400 + 32'(i * 16); l1a_evict_line = 128'(i + 1);
      l1a_evict_wren = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
    repeat (25) @(negedge clk);
    check_eq("t5 ovfa",   overflow_a, 1'b1);
    check_eq("t5 ovfb",   overflow_b, 1'b0);
    check_eq("t5 fb cnt", fb_log.size(), 1);
    check_eq("t5 wr cnt", wr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t5 wr%0d addr", i), log_addr(wr_log, i), 32'h400 + 32'(i * 16));
      check_eq($sformatf("t5 wr%0d data", i), log_data(wr_log, i), 128'(i + 1));
    end
    check_eq("t5 wr after fill", log_cyc(wr_log, 0) > log_cyc(fb_log, 0) - 1, 1'b1);

    // Test 6: reset during WAIT_RD abandons the read
    do_reset();
    l1a_addr = 32'h500; l1a_read_req = 1'b1; t0 = cyc;
    @(negedge clk); clear_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("t6 mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("t6 rd0 addr", log_addr(rd_log, 0), 32'h500);
    check_eq("t6 fa none",  fa_log.size(), 0);
    check_eq("t6 fb none",  fb_log.size(), 0);
    check_eq("t6 fla zero", l1a_fill_line, '0);
    l1a_addr = 32'h600; l1a_read_req = 1'b1; t0 = cyc;
    @(negedge clk); clear_inputs();
    repeat (14) @(negedge clk);
    check_eq("t6 rd1 addr", log_addr(rd_log, 1), 32'h600);
    check_eq("t6 rd1 lat",  log_cyc(rd_log, 1) - t0, 2);
    check_eq("t6 fa cnt",   fa_log.size(), 1);
    check_eq("t6 fa data",  log_data(fa_log, 0), model_line(32'h600));
    check_eq("t6 fa lat",   log_cyc(fa_log, 0) - t0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
